// File: rtl/mult_seq_if.sv
// Handshake and operand/result bundle between the control unit and the
// sequential multiplier.
interface mult_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_seq.sv
// Multi-cycle shift-add multiplier for MULT/MULTU: operates on operand
// magnitudes for WIDTH iterations, then applies the sign in a final FIX step.
module mult_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst_n,
    mult_seq_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH:0]     acc_r, acc_s;
    logic [WIDTH-1:0]   mq_r, mq_s;
    logic [WIDTH-1:0]   mcand_r, mcand_s;
    logic               neg_r, neg_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [WIDTH-1:0]   hi_r, hi_s;
    logic [WIDTH-1:0]   lo_r, lo_s;

    logic [WIDTH:0]     addend_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] prod_s;

    // Unsigned magnitude of an operand; the most negative value maps onto
    // itself, which is correct when read as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        logic [WIDTH-1:0] m;
        if (sgn && v[WIDTH-1]) begin
            m = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Next-state and datapath: one add/shift per CALC cycle, sign fix in FIX.
    always_comb begin
        state_s  = state_r;
        acc_s    = acc_r;
        mq_s     = mq_r;
        mcand_s  = mcand_r;
        neg_s    = neg_r;
        cnt_s    = cnt_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        hi_s     = hi_r;
        lo_s     = lo_r;
        addend_s = mq_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}};
        sum_s    = acc_r + addend_s;
        prod_s   = {acc_r[WIDTH-1:0], mq_r};

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    mcand_s = magnitude(bus.a, bus.is_signed);
                    mq_s    = magnitude(bus.b, bus.is_signed);
                    acc_s   = {(WIDTH+1){1'b0}};
                    neg_s   = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    cnt_s   = {CNT_W{1'b0}};
                    busy_s  = 1'b1;
                    state_s = ST_CALC;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            ST_CALC: begin
                // Low bit of the sum drops into the top of mq as the pair shifts right.
                acc_s = {1'b0, sum_s[WIDTH:1]};
                mq_s  = {sum_s[0], mq_r[WIDTH-1:1]};
                cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX: begin
                if (neg_r) begin
                    prod_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    prod_s = {acc_r[WIDTH-1:0], mq_r};
                end
                hi_s    = prod_s[2*WIDTH-1:WIDTH];
                lo_s    = prod_s[WIDTH-1:0];
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= {(WIDTH+1){1'b0}};
            mq_r    <= {WIDTH{1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            neg_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            mq_r    <= mq_s;
            mcand_r <= mcand_s;
            neg_r   <= neg_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
        end
    end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Multi-cycle shift-add multiplier for MULT/MULTU, using the 32-bit adder datapath.
- Each iteration presents an accumulator and multiplicand to a WIDTH+1-bit add and takes back the sum, so it sits directly upstream of the adder.
- Writes a 2*WIDTH-bit product into HI/LO-facing outputs.
- Handshake with the control unit uses start/busy/done so the pipeline can stall until the result is ready.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when hi/lo are updated.
- hi  output  WIDTH  upper half of product.
- lo  output  WIDTH  lower half of product.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal acc/mq/mcand/neg cleared. Takes effect immediately, including mid-operation. The in-flight result is discarded and hi/lo read 0.

States: IDLE, CALC, FIX.

IDLE:
- done is driven 0 except in the cycle right after FIX.
- On a clock edge with start=1:
  - mcand = |a| if is_signed and a[WIDTH-1]=1, else a.
  - mq = |b|, with the same rule applied to b.
  - acc = 0.
  - neg = is_signed & (a[MSB]^b[MSB]).
  - counter = 0.
  - busy = 1; go to CALC.
- Magnitude of the most negative value (0x80000000) is 0x80000000, treated as unsigned WIDTH bits.

CALC, one iteration per edge:
- sum = acc + (mq[0] ? {1'b0,mcand} : 0), WIDTH+1 bits, no overflow possible.
- {acc,mq} = {sum,mq} >> 1; acc keeps WIDTH+1 bits with a zero shifted in.
- counter++.
- On the edge where counter reaches WIDTH-1, go to FIX. This gives exactly WIDTH iterations.

FIX (one edge):
- p = {acc[WIDTH-1:0], mq}; if neg, p = ~p + 1 (2*WIDTH-bit two's complement).
- hi = p[2W-1:W]; lo = p[W-1:0]; done = 1; busy = 0; go to IDLE.

Latency and handshake:
- Start captured at edge E0. busy=1 after E0. Iterations occur at E1..E32. FIX executes at E33, after which done=1 and busy=0.
- Total: 33 cycles from the start edge to valid hi/lo (WIDTH+1 in general).
- done is high for exactly one cycle, then returns to 0.
- start while busy=1 (CALC/FIX) is ignored; operands are not re-sampled.
- start asserted in the same cycle done=1 (state IDLE) is accepted, giving back-to-back operation.
- hi/lo change only in FIX or on reset and otherwise hold the last result. Operand inputs may change freely after E0.
- A zero operand gives product 0, with neg irrelevant because the negation of 0 is 0.
- No overflow output: the full 2*WIDTH product is always exact.

Test Plan:
- Unsigned basic: a=3, b=5, is_signed=0, start pulse -> busy high for 33 cycles, done pulse once; hi=0x00000000, lo=0x0000000F.
- Unsigned max: a=b=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed mixed: a=0xFFFFFFF9 (-7), b=3, is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- Signed extremes:
  - a=b=0x80000000, is_signed=1 -> hi=0x40000000, lo=0x00000000.
  - a=b=0xFFFFFFFF, is_signed=1 -> hi=0, lo=1.
- Handshake:
  - Pulse start with a=2, b=2, then pulse start again with a=9, b=9 at cycle 10 while busy -> ignored; result hi=0, lo=4.
  - Start with a=6, b=7 in the done cycle -> accepted; second done 33 cycles later with lo=42.
- Reset mid-op: start a=0x1234, b=0x10, deassert rst_n at cycle 15 for 2 cycles -> busy=0, done=0, hi=lo=0 immediately, no done pulse afterward. A new start a=4, b=4 then yields lo=16.
